// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and
// load/store. Accesses are serialized and the fixed read latency is sequenced.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [2:0]        streak_q, streak_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic contested;
  logic fetch_first;

  // Fetch only overrides data once data has won MAX_STREAK contested rounds.
  assign contested   = if_req && d_req;
  assign fetch_first = contested && (streak_q == STREAK_MAX);

  assign if_gnt = (state_q == IDLE) && !rst && if_req && (!d_req || fetch_first);
  assign d_gnt  = (state_q == IDLE) && !rst && d_req && !fetch_first;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_gnt) begin
          owner_d    = OWN_IF;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
          streak_d   = '0;
          state_d    = ISSUE;
        end else if (d_gnt) begin
          owner_d     = OWN_D;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_we ? d_wdata : '0;
          streak_d    = contested ? streak_q + 3'd1 : 3'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = RESP;
        end else begin
          lat_cnt_d = LAT_INIT;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
          else                   d_rdata_d  = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_cnt_q   <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_valid   = (state_q == RESP) && (owner_q == OWN_D);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT 2, 1 and 7,
// each with a behavioural fixed-latency memory.
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req    [N];
  logic [15:0] if_addr   [N];
  logic        if_gnt    [N];
  logic        if_valid  [N];
  logic [15:0] if_rdata  [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [15:0] d_addr    [N];
  logic [15:0] d_wdata   [N];
  logic        d_gnt     [N];
  logic        d_valid   [N];
  logic [15:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [15:0] mem_addr  [N];
  logic [15:0] mem_wdata [N];
  logic        busy      [N];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 7;
  endfunction

  function automatic logic [15:0] read_mem(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [15:0] pipe [8];

    mem_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .MAX_STREAK(3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_valid(if_valid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_valid(d_valid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(pipe[LAT-1]), .busy(busy[g])
    );

    // Read data shows up exactly LAT cycles after the mem_en cycle; junk otherwise.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? read_mem(mem_addr[g]) : 16'hDEAD;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      check("gnt_excl", 32'(if_gnt[g] && d_gnt[g]), 0);
      check("valid_excl", 32'(if_valid[g] && d_valid[g]), 0);
      if (!mem_en[g]) begin
        check("mem_idle_addr", 32'({mem_we[g], mem_addr[g]}), 0);
        check("mem_idle_wdata", 32'(mem_wdata[g]), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input int g);
    check("rst_ctl", 32'({if_gnt[g], d_gnt[g], if_valid[g], d_valid[g],
                          mem_en[g], mem_we[g], busy[g]}), 0);
    check("rst_mem", {mem_addr[g], mem_wdata[g]}, 0);
    check("rst_rdata", {if_rdata[g], d_rdata[g]}, 0);
  endtask

  task automatic wait_idle(input int g);
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (!busy[g]) break;
    end
    check("wait_idle", 32'(busy[g]), 0);
  endtask

  // Back-to-back loads held on d_req; checks grant spacing, latency and data.
  task automatic sweep(input int g, input int nloads);
    int          lat;
    int          gcnt;
    int          vcnt;
    int          last_g;
    logic        upd;
    int          due [$];
    logic [15:0] exp_q [$];
    lat = lat_of(g);
    gcnt = 0; vcnt = 0; last_g = 0; upd = 1'b0;
    step();
    d_req[g] = 1'b1; d_we[g] = 1'b0; d_addr[g] = 16'h0100;
    for (int k = 0; k < 150 && vcnt < nloads; k++) begin
      if (k > 0) begin
        step();
        if (upd) begin
          if (gcnt < nloads) d_addr[g] = 16'(16'h0100 + gcnt);
          else               d_req[g]  = 1'b0;
          upd = 1'b0;
        end
      end
      #1;
      if (d_gnt[g]) begin
        if (gcnt > 0) check($sformatf("lat%0d_gap", lat), 32'(cyc - last_g), 32'(lat + 3));
        last_g = cyc;
        due.push_back(cyc + lat + 2);
        exp_q.push_back(read_mem(d_addr[g]));
        gcnt++;
        upd = 1'b1;
      end
      if (d_valid[g]) begin
        if (due.size() == 0) begin
          check($sformatf("lat%0d_spurious", lat), 1, 0);
        end else begin
          check($sformatf("lat%0d_latency", lat), 32'(cyc), 32'(due.pop_front()));
          check($sformatf("lat%0d_data", lat), 32'(d_rdata[g]), 32'(exp_q.pop_front()));
        end
        vcnt++;
      end
    end
    d_req[g] = 1'b0;
    check($sformatf("lat%0d_count", lat), 32'(vcnt), 32'(nloads));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] order;
    int         n;

    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0; d_req[g] = 1'b0;
      d_we[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
    end
    if_req[0] = 1'b1; d_req[1] = 1'b1;
    step(); step(); #1;
    check_reset_outs(0);
    check("rst_if_gnt", 32'(if_gnt[0]), 0);
    check("rst_d_gnt", 32'(d_gnt[1]), 0);
    if_req[0] = 1'b0; d_req[1] = 1'b0;
    step();
    rst = 1'b0;

    // Fetch read at 0x0010, MEM_LAT=2.
    step();
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    #1;
    check("t1_if_gnt", 32'(if_gnt[0]), 1);
    check("t1_d_gnt", 32'(d_gnt[0]), 0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) if_req[0] = 1'b0;
      #1;
      check("t1_busy", 32'(busy[0]), 32'(c <= 4));
      check("t1_mem_en", 32'(mem_en[0]), 32'(c == 1));
      check("t1_if_valid", 32'(if_valid[0]), 32'(c == 4));
      if (c == 1) check("t1_mem_addr", 32'(mem_addr[0]), 32'h0010);
      if (c == 4) check("t1_if_rdata", 32'(if_rdata[0]), 32'h1234);
    end

    // Simultaneous requests with streak 0: data first, then fetch.
    step();
    if_req[0] = 1'b1; if_addr[0] = 16'h0030;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0020;
    #1;
    check("t2_d_gnt", 32'(d_gnt[0]), 1);
    check("t2_if_gnt0", 32'(if_gnt[0]), 0);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) d_req[0] = 1'b0;
      if (c == 6) if_req[0] = 1'b0;
      #1;
      check("t2_if_gnt", 32'(if_gnt[0]), 32'(c == 5));
      check("t2_d_valid", 32'(d_valid[0]), 32'(c == 4));
      check("t2_if_valid", 32'(if_valid[0]), 32'(c == 9));
      if (c == 4) check("t2_d_rdata", 32'(d_rdata[0]), 32'(read_mem(16'h0020)));
      if (c == 9) check("t2_if_rdata", 32'(if_rdata[0]), 32'(read_mem(16'h0030)));
    end

    // Both requests held: grant order D,D,D,F,D,D,D,F.
    step();
    if_req[0] = 1'b1; if_addr[0] = 16'h0080;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0050;
    order = '0; n = 0;
    for (int k = 0; k < 200 && n < 8; k++) begin
      if (k > 0) step();
      #1;
      if (d_gnt[0] || if_gnt[0]) begin
        order = {order[6:0], d_gnt[0]};
        n++;
      end
    end
    check("t3_order", 32'(order), 32'h0000_00EE);
    check("t3_count", 32'(n), 8);
    step();
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    wait_idle(0);

    // Store to 0x0040; d_rdata keeps the last load (0x0050).
    step();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'hBEEF;
    #1;
    check("t4_d_gnt", 32'(d_gnt[0]), 1);
    step();
    d_req[0] = 1'b0; d_we[0] = 1'b0; d_wdata[0] = '0;
    #1;
    check("t4_mem_ctl", 32'({mem_en[0], mem_we[0]}), 32'b11);
    check("t4_mem_addr", 32'(mem_addr[0]), 32'h0040);
    check("t4_mem_wdata", 32'(mem_wdata[0]), 32'hBEEF);
    check("t4_d_valid_early", 32'(d_valid[0]), 0);
    step(); #1;
    check("t4_d_valid", 32'(d_valid[0]), 1);
    check("t4_d_rdata", 32'(d_rdata[0]), 32'(read_mem(16'h0050)));
    check("t4_busy", 32'(busy[0]), 1);
    step();
    if_req[0] = 1'b1; if_addr[0] = 16'h0090;
    #1;
    check("t4_next_gnt", 32'(if_gnt[0]), 1);
    check("t4_d_valid_end", 32'(d_valid[0]), 0);
    step();
    if_req[0] = 1'b0;
    wait_idle(0);
    check("t4_if_rdata", 32'(if_rdata[0]), 32'(read_mem(16'h0090)));

    // Reset during WAIT of a load aborts it; fetch after release completes.
    step();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0060;
    #1;
    check("t5_d_gnt", 32'(d_gnt[0]), 1);
    step();
    d_req[0] = 1'b0;
    step(); #1;
    check("t5_busy_wait", 32'(busy[0]), 1);
    rst = 1'b1; if_req[0] = 1'b1; if_addr[0] = 16'h0070;
    #1;
    check_reset_outs(0);
    step(); #1;
    check_reset_outs(0);
    step();
    rst = 1'b0;
    #1;
    check("t5_first_gnt", 32'(if_gnt[0]), 1);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) if_req[0] = 1'b0;
      #1;
      check("t5_no_d_valid", 32'(d_valid[0]), 0);
      check("t5_if_valid", 32'(if_valid[0]), 32'(c == 4));
      if (c == 4) check("t5_if_rdata", 32'(if_rdata[0]), 32'(read_mem(16'h0070)));
    end

    // Latency sweeps with back-to-back loads.
    sweep(1, 3);
    sweep(2, 3);
    sweep(0, 3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port unified 16-bit memory between the instruction-fetch requester and the load/store requester, which is driven by the control unit's MemRead/MemWrite. It serializes accesses, sequences the memory's fixed read latency, returns read data to the correct requester, and prevents load/store traffic from starving fetch. It sits between the fetch/memory stages and the memory macro.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory read latency in cycles, legal range 1..7
- MAX_STREAK, 3, maximum consecutive contested data grants before fetch is forced, legal range 1..7

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetch read data (registered)
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_valid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  load data (registered)
- mem_en  out  1  one-cycle memory access strobe (registered)
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is pending, assert exactly one grant, latch owner/addr/we/wdata at the clock edge, and go to ISSUE. With no request, stay in IDLE.
- ISSUE: mem_en=1 for one cycle with the latched payload. A read goes to WAIT with the latency counter set to MEM_LAT. A store goes to RESP.
- WAIT: counter decrements each cycle. In the final WAIT cycle, capture mem_rdata into the owner's rdata register at the clock edge, then go to RESP.
- RESP: pulse the owner's valid for one cycle, then go to IDLE.
- Grants are issued only in IDLE. A request held high after its grant counts as a new request.
- Arbitration: data wins over fetch, except when the streak counter equals MAX_STREAK and both requests are pending. In that case fetch wins.
- Streak counter (3 bits):
  - Contested data grant: increment.
  - Fetch grant: clear.
  - Uncontested data grant: clear.
- if_rdata and d_rdata hold their value until the next read for that owner. Stores never modify d_rdata.
- Never assert both grants, or both valids, in the same cycle.

## Timing
- Reset (asynchronous) sets:
  - State: IDLE, streak counter 0.
  - Outputs 0: if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, busy.
- Grant in cycle T:
  - mem_en in T+1.
  - Read: data captured at the end of T+1+MEM_LAT; valid in T+2+MEM_LAT.
  - Store: valid in T+2.
- Next possible grant:
  - Read: cycle T+3+MEM_LAT, so read throughput is one per MEM_LAT+3 cycles.
  - Store: cycle T+3.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.
- A request that drops before being granted has no effect.
- Reset asserted mid-transaction (ISSUE/WAIT/RESP) aborts it: no valid pulse, mem_en low immediately. The first grant after reset release is legal in the first IDLE cycle.
- busy is 1 from T+1 through the RESP cycle.

## Test plan
- Fetch read, MEM_LAT=2, if_addr=0x0010, memory word 0x1234, grant at cycle 0 -> mem_en=1 and mem_addr=0x0010 at cycle 1; if_valid=1 and if_rdata=0x1234 at cycle 4; busy=1 in cycles 1-4.
- Simultaneous if_req and d_req (load 0x0020) in IDLE with streak 0 -> d_gnt first; if_gnt at the next IDLE; the two valid pulses are never coincident.
- MAX_STREAK=3, if_req and d_req both held high continuously -> grant order D,D,D,F,D,D,D,F.
- Store: d_we=1, d_addr=0x0040, d_wdata=0xBEEF, granted at cycle 0 -> mem_en=1, mem_we=1, mem_addr=0x0040, mem_wdata=0xBEEF at cycle 1; d_valid at cycle 2; d_rdata unchanged.
- rst pulsed during WAIT of a load -> no d_valid ever; all outputs 0 during reset. A fetch requested after release is granted in the first cycle and completes normally.
- MEM_LAT=1 and MEM_LAT=7 sweeps with back-to-back loads -> valid exactly MEM_LAT+2 cycles after each grant; grants spaced MEM_LAT+3 cycles apart.
